// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer that issues ops to a shared combinational ALU
// Holds operands on alu_* for the op's latency, then presents the captured result.
module alu_seq #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic [3:0]  in_func,
  input  logic [3:0]  in_inner,
  output logic [63:0] alu_src1,
  output logic [63:0] alu_src2,
  output logic [3:0]  alu_func,
  output logic [3:0]  alu_inner,
  input  logic [63:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_divz,
  input  logic        flush,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_result_q, out_result_d;
  logic        out_divz_q, out_divz_d;
  logic [63:0] alu_src1_q, alu_src1_d;
  logic [63:0] alu_src2_q, alu_src2_d;
  logic [3:0]  alu_func_q, alu_func_d;
  logic [3:0]  alu_inner_q, alu_inner_d;

  logic        accept;
  logic        div_zero;
  logic [7:0]  start_cnt;

  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign div_zero = (in_func == 4'd3) && (in_src2 == 64'd0);

  // Counter preload is latency minus one; a divide by zero falls through as a 1-cycle op.
  always_comb begin
    start_cnt = 8'd0;
    if (in_func == 4'd5) begin
      start_cnt = MUL_CNT;
    end else if ((in_func == 4'd3) && !div_zero) begin
      start_cnt = DIV_CNT;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_divz_d   = out_divz_q;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    alu_func_d   = alu_func_q;
    alu_inner_d  = alu_inner_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            out_result_d = alu_result;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end
        end
        DONE: begin
          if (out_ready && !in_valid) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
      // Accept covers both IDLE and the same-edge complete+issue out of DONE.
      if (accept) begin
        state_d     = EXEC;
        out_valid_d = 1'b0;
        cnt_d       = start_cnt;
        out_divz_d  = div_zero;
        alu_src1_d  = in_src1;
        alu_src2_d  = in_src2;
        alu_func_d  = in_func;
        alu_inner_d = in_inner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      out_valid_q  <= 1'b0;
      out_result_q <= 64'd0;
      out_divz_q   <= 1'b0;
      alu_src1_q   <= 64'd0;
      alu_src2_q   <= 64'd0;
      alu_func_q   <= 4'd0;
      alu_inner_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_divz_q   <= out_divz_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      alu_func_q   <= alu_func_d;
      alu_inner_q  <= alu_inner_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_divz   = out_divz_q;
  assign alu_src1   = alu_src1_q;
  assign alu_src2   = alu_src2_q;
  assign alu_func   = alu_func_q;
  assign alu_inner  = alu_inner_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq
// A behavioural ALU drives alu_result; expected results and latencies come from the op rules.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic [3:0]  in_func = '0;
  logic [3:0]  in_inner = '0;
  logic [63:0] alu_src1, alu_src2;
  logic [3:0]  alu_func, alu_inner;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_divz;
  logic        flush = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_seq #(.MUL_LAT(3), .DIV_LAT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_func(in_func), .in_inner(in_inner),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_func(alu_func), .alu_inner(alu_inner),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_divz(out_divz), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [3:0] f, input logic [3:0] inr,
                                          input logic [63:0] a, input logic [63:0] b);
    case (f)
      4'd0: return inr[0] ? a - b : a + b;
      4'd1: case (inr[1:0])
              2'd0: return a & b;
              2'd1: return a | b;
              2'd2: return a ^ b;
              default: return ~(a | b);
            endcase
      4'd2: return a << b[5:0];
      4'd3: return (b == 64'd0) ? '1 : a / b;
      4'd4: return (a < b) ? 64'd1 : 64'd0;
      4'd5: return a * b;
      4'd6: return {a[31:0], b[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] f, input logic [63:0] b);
    if (f == 4'd5) return 3;
    if (f == 4'd3 && b != 64'd0) return 16;
    return 1;
  endfunction

  always_comb alu_result = ref_alu(alu_func, alu_inner, alu_src1, alu_src2);

  // Issues one op from IDLE, reports observed latency/result and stability flags, then pops it.
  task automatic run_op(input logic [3:0] f, input logic [3:0] inr, input logic [63:0] a,
                        input logic [63:0] b, input int hold, output int lat,
                        output logic [63:0] res, output logic dz,
                        output bit ok_stable, output bit ok_ready);
    ok_stable = 1'b1;
    ok_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_func = f; in_inner = inr; in_src1 = a; in_src2 = b; out_ready = 1'b0;
    if (!in_ready) ok_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
    in_func = 4'($urandom); in_inner = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (in_ready || !busy) ok_ready = 1'b0;
      if (alu_src1 !== a || alu_src2 !== b || alu_func !== f || alu_inner !== inr) ok_stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = out_result;
    dz  = out_divz;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || !busy || out_result !== res || out_divz !== dz) ok_stable = 1'b0;
      if (alu_src1 !== a || alu_src2 !== b || alu_func !== f || alu_inner !== inr) ok_stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, busy, out_divz, out_result, alu_src1, alu_src2, alu_func, alu_inner} !== '0) begin
      fails++; $display("FAIL reset_outputs: got valid=%0b busy=%0b divz=%0b res=%h src1=%h, want all 0",
                        out_valid, busy, out_divz, out_result, alu_src1);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    int lat; logic [63:0] res; logic dz; bit st, rd;
    run_op(4'd0, 4'd0, 64'd5, 64'd7, 0, lat, res, dz, st, rd);
    tests++; if (lat != 1) begin fails++; $display("FAIL add_latency: got %0d want 1", lat); end
    tests++; if (res !== 64'd12) begin fails++; $display("FAIL add_result: got %0d want 12", res); end
    tests++; if (!rd) begin fails++; $display("FAIL add_in_ready: got handshake error want none"); end
  endtask

  task automatic test_mul;
    int lat; logic [63:0] res; logic dz; bit st, rd;
    run_op(4'd5, 4'd0, 64'd6, 64'd7, 2, lat, res, dz, st, rd);
    tests++; if (lat != 3) begin fails++; $display("FAIL mul_latency: got %0d want 3", lat); end
    tests++; if (res !== 64'd42) begin fails++; $display("FAIL mul_result: got %0d want 42", res); end
    tests++; if (!st || !rd) begin fails++; $display("FAIL mul_stable: got stable=%0b ready_ok=%0b want 1 1", st, rd); end
  endtask

  task automatic test_divz;
    int lat; logic [63:0] res; logic dz; bit st, rd;
    run_op(4'd3, 4'd0, 64'd99, 64'd0, 1, lat, res, dz, st, rd);
    tests++; if (lat != 1) begin fails++; $display("FAIL divz_latency: got %0d want 1", lat); end
    tests++; if (dz !== 1'b1) begin fails++; $display("FAIL divz_flag: got %b want 1", dz); end
    tests++; if (res !== ref_alu(4'd3, 4'd0, 64'd99, 64'd0)) begin fails++; $display("FAIL divz_result: got %h want %h", res, ref_alu(4'd3, 4'd0, 64'd99, 64'd0)); end
    run_op(4'd0, 4'd0, 64'd3, 64'd4, 0, lat, res, dz, st, rd);
    tests++; if (dz !== 1'b0 || res !== 64'd7) begin fails++; $display("FAIL divz_clear: got divz=%b res=%0d want 0 7", dz, res); end
  endtask

  task automatic test_random;
    int lat; logic [63:0] res, a, b; logic dz; bit st, rd;
    logic [3:0] f, inr;
    for (int i = 0; i < 24; i++) begin
      f = 4'($urandom); inr = 4'($urandom);
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      if (f == 4'd3 && $urandom_range(0, 1) == 0) b = 64'($urandom_range(1, 1000));
      run_op(f, inr, a, b, $urandom_range(0, 3), lat, res, dz, st, rd);
      tests++;
      if (lat != ref_lat(f, b) || res !== ref_alu(f, inr, a, b) ||
          dz !== (f == 4'd3 && b == 64'd0) || !st || !rd) begin
        fails++;
        $display("FAIL random_op%0d func=%0d: got lat=%0d res=%h divz=%b stable=%0b ready=%0b want lat=%0d res=%h divz=%b",
                 i, f, lat, res, dz, st, rd, ref_lat(f, b), ref_alu(f, inr, a, b), (f == 4'd3 && b == 64'd0));
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_func = 4'd3; in_inner = 4'd0; in_src1 = 64'd100; in_src2 = 64'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    tests++; if (k != 16) begin fails++; $display("FAIL div_latency: got %0d want 16", k); end
    repeat (5) @(negedge clk);
    tests++; if (!out_valid || out_result !== 64'd14) begin fails++; $display("FAIL div_hold: got valid=%b res=%0d want 1 14", out_valid, out_result); end
    out_ready = 1'b1; in_valid = 1'b1; in_func = 4'd0; in_src1 = 64'd1; in_src2 = 64'd1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_exec: got valid=%b busy=%b want 0 1", out_valid, busy); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_result !== 64'd2 || out_divz !== 1'b0) begin
      fails++; $display("FAIL b2b_result: got valid=%b res=%0d divz=%b want 1 2 0", out_valid, out_result, out_divz);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_func = 4'd5; in_src1 = 64'd9; in_src2 = 64'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_idle: got busy=%b valid=%b in_ready=%b want 0 0 0", busy, out_valid, in_ready);
    end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_no_accept: got busy=%b want 0", busy); end
    flush = 1'b0; in_valid = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    tests++; if (seen) begin fails++; $display("FAIL flush_discard: got out_valid=1 want never"); end
  endtask

  task automatic test_reset_in_done;
    @(negedge clk);
    in_valid = 1'b1; in_func = 4'd0; in_inner = 4'd0; in_src1 = 64'd20; in_src2 = 64'd22;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_result !== 64'd42) begin fails++; $display("FAIL pre_reset_done: got valid=%b res=%0d want 1 42", out_valid, out_result); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, busy, out_divz, out_result, alu_src1, alu_src2, alu_func, alu_inner} !== '0) begin
      fails++; $display("FAIL async_reset: got valid=%b busy=%b res=%0d src1=%0d want all 0", out_valid, busy, out_result, alu_src1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_reset: got in_ready=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_divz();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_in_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: cycles from accept to result for func 5 (MUL); legal 1..255.
REQ-002 SHALL have parameter DIV_LAT, default 16: cycles from accept to result for func 3 (DIV); legal 1..255.
REQ-003 SHALL have ports: clk input 1, the single clock, all state changes on rising edge.
REQ-004 SHALL have port: rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: in_valid input 1, op request; in_ready output 1, op accepted when both high at a rising edge.
REQ-006 SHALL have ports: in_src1 input 64; in_src2 input 64; in_func input 4 (ALU unit select 0..6); in_inner input 4 (unit sub-op).
REQ-007 SHALL have ports: alu_src1 output 64; alu_src2 output 64; alu_func output 4; alu_inner output 4; these drive the shared ALU.
REQ-008 SHALL have port: alu_result input 64, combinational ALU result for the alu_* operands.
REQ-009 SHALL have ports: out_valid output 1; out_ready input 1; out_result output 64; out_divz output 1 (DIV issued with in_src2==0).
REQ-010 SHALL have ports: flush input 1, synchronous abort; busy output 1, high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, EXEC, DONE.
REQ-012 in_ready SHALL be high in IDLE, and in DONE when out_ready is high; low in EXEC and whenever flush is high.
REQ-013 On accept, SHALL register in_src1/in_src2/in_func/in_inner into alu_* outputs and enter EXEC with 8-bit cnt = LAT-1.
REQ-014 LAT SHALL be MUL_LAT for func 5, DIV_LAT for func 3 with in_src2!=0, and 1 for all other func values (0,1,2,4,6, 7..15, and DIV with in_src2==0).
REQ-015 alu_* outputs SHALL hold stable from accept until the next accept; never change during EXEC or DONE.
REQ-016 In EXEC with cnt!=0, SHALL decrement cnt; with cnt==0, SHALL capture alu_result into out_result and enter DONE.
REQ-017 out_valid SHALL be high exactly in DONE; it rises LAT cycles after the accept edge.
REQ-018 In DONE, out_result and out_divz SHALL hold until out_valid&&out_ready.
REQ-019 In DONE with out_ready high and in_valid high, SHALL complete the output and accept the new op on the same edge (go to EXEC); with in_valid low, go to IDLE.
REQ-020 out_divz SHALL be set at accept of func 3 with in_src2==0, cleared at any other accept; out_result then carries whatever alu_result is, unmodified.
REQ-021 flush high at an edge SHALL force IDLE, clear out_valid, discard any pending result, and take priority over accept and completion.
REQ-022 Func values 7..15 SHALL be sequenced as 1-cycle ops; result is the ALU output (0) without error signalling.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, cnt=0, out_valid=0, out_divz=0, out_result=0, alu_src1=alu_src2=0, alu_func=alu_inner=0, busy=0.
REQ-024 rst_n low mid-EXEC or mid-DONE SHALL discard the op; after release first accept is possible on the first rising edge with rst_n high.

Verification
REQ-025 ADD: func=0,inner=0,src1=5,src2=7 accepted at edge E0, out_ready=1 -> out_valid high after E1 only, out_result=12, in_ready low during EXEC.
REQ-026 MUL latency: func=5, MUL_LAT=3, src1=6,src2=7 -> out_valid first high after E3, out_result=42, busy high E0..E3, alu_* stable throughout.
REQ-027 Backpressure+back-to-back: DIV 100/7 (DIV_LAT=16) with out_ready=0 for 5 cycles after DONE -> out_result=14 held; then out_ready=1 with in_valid (ADD 1+1) -> same-edge complete+accept, next out_result=2 one cycle later.
REQ-028 Div-by-zero: func=3,src2=0 -> out_valid one cycle after accept, out_divz=1; following ADD clears out_divz=0.
REQ-029 Flush and reset: flush at cycle 2 of MUL -> IDLE next edge, no out_valid ever for that op; rst_n pulsed low in DONE -> out_valid drops immediately, all outputs 0.
